// File: rtl/riscv_pkg.sv
// Shared RV32I branch constants, the 2-bit predictor counter type and its update rule.
package riscv_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr2_t;

   // Saturating step: moves one state toward taken (up=1) or not-taken (up=0).
   // The end states hold, so the counter never wraps.
   function automatic ctr2_t ctr2_next(input ctr2_t cur, input logic up);
      ctr2_t nxt;
      case (cur)
         SNT:     nxt = up ? WNT : SNT;
         WNT:     nxt = up ? WT  : SNT;
         WT:      nxt = up ? ST  : WNT;
         ST:      nxt = up ? ST  : WT;
         default: nxt = WNT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sat_counter2.sv
// One branch history table entry: 2-bit saturating up/down counter with enable.
module sat_counter2
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       up,
   output logic [1:0] count
);

   ctr2_t count_r;

   // Reset to weakly not-taken; step only when this entry is being trained.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= WNT;
      end else if (en) begin
         count_r <= ctr2_next(count_r, up);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/branch_resolve_predict.sv
// EX-stage branch resolution with a bimodal predictor table, redirect PC
// generation and saturating branch/mispredict statistics.
module branch_resolve_predict
   import riscv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  if_pc,
   output logic             if_pred_taken,
   input  logic [6:0]       ex_opcode,
   input  logic [2:0]       ex_funct3,
   input  logic [XLEN-1:0]  ex_rs1,
   input  logic [XLEN-1:0]  ex_rs2,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_imm,
   input  logic             ex_pred_taken,
   input  logic             bolha,
   output logic             branch_taken,
   output logic             mispredict,
   output logic [XLEN-1:0]  redirect_pc,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam logic [XLEN-1:0]  PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             vb_s;
   logic             cond_s;
   logic             taken_s;
   logic             mispredict_s;
   logic             eq_s;
   logic             lt_s;
   logic             ltu_s;
   logic [IDX_W-1:0] if_idx_s;
   logic [IDX_W-1:0] ex_idx_s;
   logic [1:0]       bht_s [BHT_ENTRIES];
   logic [1:0]       if_ctr_s;
   logic [CNT_W-1:0] stat_branches_r;
   logic [CNT_W-1:0] stat_mispredicts_r;
   logic             unused_s;

   assign vb_s  = (ex_opcode == OPC_BRANCH) && !bolha;
   assign eq_s  = (ex_rs1 == ex_rs2);
   assign lt_s  = ($signed(ex_rs1) < $signed(ex_rs2));
   assign ltu_s = (ex_rs1 < ex_rs2);

   // Branch condition decode; the reserved funct3 codes resolve as not-taken.
   always_comb begin
      cond_s = 1'b0;
      case (ex_funct3)
         F3_BEQ:  cond_s = eq_s;
         F3_BNE:  cond_s = !eq_s;
         F3_BLT:  cond_s = lt_s;
         F3_BGE:  cond_s = !lt_s;
         F3_BLTU: cond_s = ltu_s;
         F3_BGEU: cond_s = !ltu_s;
         default: cond_s = 1'b0;
      endcase
   end

   assign taken_s      = vb_s && cond_s;
   assign mispredict_s = vb_s && (taken_s ^ ex_pred_taken);

   assign branch_taken = taken_s;
   assign mispredict   = mispredict_s;
   assign redirect_pc  = ex_pc + (taken_s ? ex_imm : PC_STEP);

   // Word-aligned PCs index the table; upper bits alias freely.
   assign if_idx_s = if_pc[IDX_W+1:2];
   assign ex_idx_s = ex_pc[IDX_W+1:2];

   for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      sat_counter2 u_ctr (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (vb_s && (ex_idx_s == IDX_W'(gi))),
         .up    (taken_s),
         .count (bht_s[gi])
      );
   end

   // Lookup reads the stored value, so a same-cycle update is not visible yet.
   assign if_ctr_s      = bht_s[if_idx_s];
   assign if_pred_taken = if_ctr_s[1];

   // Statistics: clear wins over counting, both counters stick at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_branches_r    <= {CNT_W{1'b0}};
         stat_mispredicts_r <= {CNT_W{1'b0}};
      end else if (stat_clr) begin
         stat_branches_r    <= {CNT_W{1'b0}};
         stat_mispredicts_r <= {CNT_W{1'b0}};
      end else begin
         if (vb_s && (stat_branches_r != CNT_MAX)) begin
            stat_branches_r <= stat_branches_r + CNT_ONE;
         end else begin
            stat_branches_r <= stat_branches_r;
         end
         if (mispredict_s && (stat_mispredicts_r != CNT_MAX)) begin
            stat_mispredicts_r <= stat_mispredicts_r + CNT_ONE;
         end else begin
            stat_mispredicts_r <= stat_mispredicts_r;
         end
      end
   end

   assign stat_branches    = stat_branches_r;
   assign stat_mispredicts = stat_mispredicts_r;

   assign unused_s = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], if_ctr_s[0]};

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Scoreboard bench for branch_resolve_predict: every step pushes the expected
// outputs from a behavioural predictor/stat model, then pops and compares them.
module tb_branch_resolve_predict;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_rs1;
   logic [31:0] ex_rs2;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic        ex_pred_taken;
   logic        bolha;
   logic        branch_taken;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        stat_clr;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   branch_resolve_predict dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .if_pc            (if_pc),
      .if_pred_taken    (if_pred_taken),
      .ex_opcode        (ex_opcode),
      .ex_funct3        (ex_funct3),
      .ex_rs1           (ex_rs1),
      .ex_rs2           (ex_rs2),
      .ex_pc            (ex_pc),
      .ex_imm           (ex_imm),
      .ex_pred_taken    (ex_pred_taken),
      .bolha            (bolha),
      .branch_taken     (branch_taken),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .stat_clr         (stat_clr),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] OPC_BR = 7'b1100011;

   typedef struct {
      logic        bt;
      logic        mp;
      logic [31:0] rpc;
      logic        pred;
      logic [31:0] sb;
      logic [31:0] sm;
   } exp_t;

   exp_t        sb_q[$];
   logic [1:0]  m_bht [64];
   logic [31:0] m_br;
   logic [31:0] m_mp;
   int          n_err;
   int          n_chk;

   function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
      m_br = 32'd0;
      m_mp = 32'd0;
   endfunction

   // One EX cycle: drive at negedge, compare combinational and pre-edge state, advance model at posedge.
   task automatic step(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pt, input logic bb,
                       input logic [31:0] lpc, input logic clr, input logic rst);
      exp_t e;
      exp_t g;
      logic vb;
      logic bt;
      logic mp;
      @(negedge clk);
      ex_opcode = opc; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm;
      ex_pred_taken = pt; bolha = bb; if_pc = lpc; stat_clr = clr; rst_n = ~rst;
      vb = (opc == OPC_BR) && !bb;
      bt = vb && m_cond(f3, a, b);
      mp = vb && (bt != pt);
      e.bt = bt; e.mp = mp; e.rpc = pc + (bt ? imm : 32'd4);
      e.pred = m_bht[lpc[7:2]][1]; e.sb = m_br; e.sm = m_mp;
      sb_q.push_back(e);
      #1;
      n_chk++;
      if (sb_q.size() == 0) begin
         n_err++;
         $display("FAIL %s scoreboard empty got=0 exp=1", tag);
      end else begin
         g = sb_q.pop_front();
         n_chk += 5;
         if (branch_taken !== g.bt) begin n_err++; $display("FAIL %s branch_taken got=%b exp=%b", tag, branch_taken, g.bt); end
         if (mispredict !== g.mp) begin n_err++; $display("FAIL %s mispredict got=%b exp=%b", tag, mispredict, g.mp); end
         if (redirect_pc !== g.rpc) begin n_err++; $display("FAIL %s redirect_pc got=%h exp=%h", tag, redirect_pc, g.rpc); end
         if (if_pred_taken !== g.pred) begin n_err++; $display("FAIL %s if_pred_taken got=%b exp=%b", tag, if_pred_taken, g.pred); end
         if (stat_branches !== g.sb) begin n_err++; $display("FAIL %s stat_branches got=%0d exp=%0d", tag, stat_branches, g.sb); end
         if (stat_mispredicts !== g.sm) begin n_err++; $display("FAIL %s stat_mispredicts got=%0d exp=%0d", tag, stat_mispredicts, g.sm); end
      end
      @(posedge clk);
      if (rst) begin
         m_reset();
      end else begin
         if (clr) begin
            m_br = 32'd0; m_mp = 32'd0;
         end else begin
            if (vb && m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
            if (mp && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 32'd1;
         end
         if (vb) begin
            if (bt && m_bht[pc[7:2]] != 2'b11) m_bht[pc[7:2]] = m_bht[pc[7:2]] + 2'd1;
            else if (!bt && m_bht[pc[7:2]] != 2'b00) m_bht[pc[7:2]] = m_bht[pc[7:2]] - 2'd1;
         end
      end
      #1;
      rst_n = 1'b1; stat_clr = 1'b0;
   endtask

   task automatic idle(input string tag, input logic [31:0] lpc);
      step(tag, 7'b0010011, 3'b000, 32'd5, 32'd5, 32'h0000_0300, 32'h40, 1'b0, 1'b0, lpc, 1'b0, 1'b0);
   endtask

   task automatic br(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pc, input logic pt);
      step(tag, OPC_BR, f3, a, b, pc, 32'h0000_0020, pt, 1'b0, pc, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stat_clr = 1'b0; bolha = 1'b0; ex_opcode = 7'd0; ex_funct3 = 3'd0;
      ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_pc = 32'd0; ex_imm = 32'd0; ex_pred_taken = 1'b0; if_pc = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_reset();
      idle("rst_pc0", 32'h0000_0000);
      idle("rst_pc100", 32'h0000_0100);
      idle("rst_pcfc", 32'h0000_00FC);
   endtask

   task automatic test_beq_basic();
      step("beq_taken", OPC_BR, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0);
      idle("beq_after", 32'h100);
      n_chk++;
      if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd1 || if_pred_taken !== 1'b1) begin
         n_err++;
         $display("FAIL beq_const got=%0d/%0d/%b exp=1/1/1", stat_branches, stat_mispredicts, if_pred_taken);
      end
   endtask

   task automatic test_signed_unsigned();
      br("blt", 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 1'b0);
      br("bge", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h204, 1'b1);
      br("bltu", 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h208, 1'b1);
      br("bgeu", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h20C, 1'b0);
      br("bne", 3'b001, 32'hFFFF_FFFF, 32'd1, 32'h210, 1'b1);
      br("f3_010", 3'b010, 32'd7, 32'd7, 32'h214, 1'b1);
      br("f3_011", 3'b011, 32'd7, 32'd8, 32'h218, 1'b0);
      idle("su_after", 32'h208);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 4; i++) br("sat_up", 3'b000, 32'd1, 32'd1, 32'h40, 1'b1);
      br("sat_dn1", 3'b000, 32'd1, 32'd2, 32'h40, 1'b1);
      idle("sat_wt", 32'h40);
      n_chk++;
      if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL sat_wt_const got=%b exp=1", if_pred_taken); end
      for (int i = 0; i < 4; i++) br("sat_down", 3'b000, 32'd1, 32'd2, 32'h40, 1'b0);
      br("sat_one_up", 3'b000, 32'd1, 32'd1, 32'h40, 1'b0);
      idle("sat_floor", 32'h40);
      n_chk++;
      if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL sat_floor_const got=%b exp=0", if_pred_taken); end
   endtask

   task automatic test_bolha();
      step("bolha", OPC_BR, 3'b000, 32'd9, 32'd9, 32'h180, 32'h40, 1'b1, 1'b1, 32'h180, 1'b0, 1'b0);
      step("bolha2", OPC_BR, 3'b000, 32'd9, 32'd9, 32'h180, 32'h40, 1'b0, 1'b1, 32'h180, 1'b0, 1'b0);
      idle("bolha_after", 32'h180);
   endtask

   task automatic test_aliasing();
      br("alias_t0", 3'b000, 32'd3, 32'd3, 32'h000, 1'b0);
      idle("alias_100", 32'h100);
      idle("alias_004", 32'h004);
      n_chk++;
      if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_004_const got=%b exp=0", if_pred_taken); end
   endtask

   task automatic test_same_edge();
      step("clr_mp", OPC_BR, 3'b000, 32'd1, 32'd1, 32'h1C0, 32'h8, 1'b0, 1'b0, 32'h1C0, 1'b1, 1'b0);
      idle("clr_after", 32'h1C0);
      n_chk++;
      if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
         n_err++;
         $display("FAIL clr_const got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
      end
      br("rst_pre1", 3'b000, 32'd1, 32'd1, 32'h80, 1'b0);
      br("rst_pre2", 3'b000, 32'd1, 32'd1, 32'h80, 1'b1);
      step("rst_train", OPC_BR, 3'b000, 32'd1, 32'd1, 32'h80, 32'h8, 1'b1, 1'b0, 32'h80, 1'b0, 1'b1);
      br("rst_nt", 3'b001, 32'd1, 32'd1, 32'h80, 1'b0);
      idle("rst_entry", 32'h80);
      br("lookup_same", 3'b000, 32'd2, 32'd2, 32'h80, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [2:0] f3;
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         step("rand", ($urandom_range(0, 5) == 0) ? 7'b0110011 : OPC_BR, f3,
              32'($urandom_range(0, 3)) - 32'd1, 32'($urandom_range(0, 3)) - 32'd1,
              {24'd0, 6'($urandom_range(0, 7)), 2'b00}, 32'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), {24'd0, 6'($urandom_range(0, 7)), 2'b00},
              ($urandom_range(0, 15) == 0), 1'b0);
      end
      idle("rand_end", 32'h0);
   endtask

   initial begin
      n_err = 0;
      n_chk = 0;
      test_reset();
      test_beq_basic();
      test_signed_unsigned();
      test_saturation();
      test_bolha();
      test_aliasing();
      test_same_edge();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/branch_resolve_predict.md
Name: branch_resolve_predict

Overview:
- Next-generation branch unit for the RV32I pipeline. Resolves conditional branches in EX, with XLEN generalised.
- Adds a BHT_ENTRIES-deep table of 2-bit saturating predictors, read at fetch and trained at resolution.
- Flags mispredictions and supplies the redirect PC to IF.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- XLEN, 32, datapath and PC width.
- BHT_ENTRIES, 64, number of predictor entries; power of two, at least 2.
- IDX_W, $clog2(BHT_ENTRIES), table index width; derived, not overridden.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- if_pc  in  XLEN  fetch PC for lookup
- if_pred_taken  out  1  prediction for if_pc (counter MSB)
- ex_opcode  in  7  instruction opcode in EX
- ex_funct3  in  3  branch condition
- ex_rs1  in  XLEN  forwarded rs1 value
- ex_rs2  in  XLEN  forwarded rs2 value
- ex_pc  in  XLEN  PC of the EX instruction
- ex_imm  in  XLEN  sign-extended B-immediate
- ex_pred_taken  in  1  prediction carried down the pipe from IF
- bolha  in  1  EX slot holds a bubble/flushed instr; suppresses all effects
- branch_taken  out  1  actual outcome (combinational)
- mispredict  out  1  actual outcome differs from ex_pred_taken (combinational)
- redirect_pc  out  XLEN  taken: ex_pc+ex_imm; not taken: ex_pc+4
- stat_clr  in  1  synchronous clear of the statistics counters
- stat_branches  out  CNT_W  resolved-branch count
- stat_mispredicts  out  CNT_W  mispredict count

Behaviour:
- Valid branch: vb = (ex_opcode==7'b1100011) & ~bolha.
- Conditions follow the RV32I encoding:
  - 000 BEQ, 001 BNE: equality compare.
  - 100 BLT, 101 BGE: signed compare.
  - 110 BLTU, 111 BGEU: unsigned compare.
  - 010/011: branch_taken=0, treated as not-taken; training and counting still occur.
- branch_taken = vb & cond. mispredict = vb & (branch_taken ^ ex_pred_taken). With vb=0 both are 0.
- redirect_pc is always driven: ex_pc + (branch_taken ? ex_imm : 4), modulo 2^XLEN. Wrap-around is ignored.
- Table index = pc[IDX_W+1:2] for both if_pc and ex_pc. PC bits [1:0] are ignored.
- Prediction lookup is combinational: if_pred_taken = bht[idx(if_pc)][1]. It is combinational, with no registered stage.
- Training: on a rising edge with vb=1, bht[idx(ex_pc)] increments if taken and decrements if not. Saturates at 2'b11 and 2'b00; no wrap.
- Same-cycle read and write to one index: if_pred_taken shows the pre-update value, with no bypass.
- Counters:
  - stat_branches increments on every vb cycle.
  - stat_mispredicts increments on every mispredict cycle.
  - Both saturate at all-ones.
  - stat_clr takes priority over increment and zeroes both on that edge.
- Reset (rst_n=0 at an edge):
  - Every BHT entry goes to 2'b01 (weakly not-taken); statistics counters go to 0.
  - Reset overrides training and stat_clr.
  - Reset is honoured mid-stream; a branch in EX during reset does not train.
- After reset:
  - if_pred_taken = 0 for every PC; counters read 0.
  - branch_taken, mispredict and redirect_pc depend only on current inputs.

Decomposition:
- Shared package (riscv_pkg):
  - OPC_BRANCH = 7'b1100011.
  - F3_BEQ/BNE/BLT/BGE/BLTU/BGEU constants.
  - 2-bit counter typedef with SNT/WNT/WT/ST encodings 00/01/10/11.
- One sub-module, sat_counter2: 2-bit saturating up/down counter with enable. It is instantiated per BHT entry through a generate loop, or implemented as an update function.
- The condition-compare logic stays inline.

Test Plan:
- Reset, then BEQ with rs1=rs2=5, ex_pred_taken=0, ex_pc=0x100, imm=0x20:
  - branch_taken=1, mispredict=1, redirect_pc=0x120.
  - Next cycle, if_pc=0x100 still gives if_pred_taken=1 (counter 01→10); stat_branches=1, stat_mispredicts=1.
- Signed/unsigned split with rs1=0xFFFFFFFF, rs2=1:
  - BLT taken, BGE not taken.
  - BLTU not taken, BGEU taken.
  - BNE taken.
- Saturation, PC 0x40: four consecutive taken branches give entry 11; one not-taken gives 10, if_pred_taken still 1. Then three not-taken give 00; a further not-taken keeps 00.
- bolha=1 with a valid branch encoding and rs1=rs2, funct3=000:
  - branch_taken=0, mispredict=0.
  - No BHT change; counters unchanged.
- Aliasing with BHT_ENTRIES=64: training PC 0x000 moves the prediction for PC 0x100; PC 0x004 is unaffected.
- Same-edge events:
  - stat_clr asserted with a mispredicting branch: counters read 0 next cycle.
  - rst_n=0 asserted with a training branch: entry reads 01.
  - Lookup at the index being trained: pre-update MSB is returned.
